// File: rtl/nibble_datapath.sv
// nibble_datapath: fetch register, 4-bit ALU and accumulator of the nibble CPU; ALU_EXT_OPS_EN adds XOR/OR/shift-left
module nibble_datapath (
    input  logic       clk,
    input  logic       R,
    input  logic       fetch_en,
    input  logic [7:0] programb,
    input  logic       loadA,
    input  logic [2:0] fun,
    input  logic [3:0] databus,
    output logic [3:0] instr,
    output logic [3:0] operando,
    output logic [3:0] accu,
    output logic [3:0] alu,
    output logic       carry,
    output logic       zero
);
    logic [4:0] sum;

    // ALU: {carry,alu} from accumulator (A) and data bus (B)
    always_comb begin
        sum = 5'h0;
        case (fun)
            3'b000:  sum = {1'b0, accu};
            3'b001:  sum = {1'b0, accu} + {1'b0, ~databus} + 5'd1;
            3'b010:  sum = {1'b0, databus};
            3'b011:  sum = {1'b0, accu} + {1'b0, databus};
            3'b100:  sum = {1'b0, ~(accu & databus)};
`ifdef ALU_EXT_OPS_EN
            3'b101:  sum = {1'b0, accu ^ databus};
            3'b110:  sum = {1'b0, accu | databus};
            3'b111:  sum = {accu, 1'b0};
`endif
            default: sum = 5'h0;
        endcase
    end

    assign alu   = sum[3:0];
    assign carry = sum[4];
    assign zero  = (alu == 4'h0);

    // fetch register splits the program byte; accumulator captures the ALU result
    always_ff @(posedge clk) begin
        if (R) begin
            instr    <= 4'h0;
            operando <= 4'h0;
            accu     <= 4'h0;
        end else begin
            if (fetch_en) {instr, operando} <= programb;
            if (loadA) accu <= alu;
        end
    end
endmodule

// File: tb/tb_nibble_datapath.sv
// tb_nibble_datapath: directed and randomized checks of nibble_datapath against an arithmetic model
module tb_nibble_datapath;
    logic       clk = 1'b0;
    logic       R = 1'b1;
    logic       fetch_en = 1'b0;
    logic [7:0] programb = 8'h00;
    logic       loadA = 1'b0;
    logic [2:0] fun = 3'b000;
    logic [3:0] databus = 4'h0;
    logic [3:0] instr, operando, accu, alu;
    logic       carry, zero;

    int errors = 0;
    int checks = 0;
    logic [3:0] m_instr, m_oper, m_accu;

    nibble_datapath dut (
        .clk(clk), .R(R), .fetch_en(fetch_en), .programb(programb), .loadA(loadA),
        .fun(fun), .databus(databus), .instr(instr), .operando(operando), .accu(accu),
        .alu(alu), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // returns {carry, alu} from the function table using plain integer arithmetic
    function automatic logic [4:0] ref_alu(input int f, input int a, input int b);
        int r, c;
        r = 0;
        c = 0;
        case (f)
            0: r = a;
            1: begin r = (a - b + 16) % 16; c = (a >= b) ? 1 : 0; end
            2: r = b;
            3: begin r = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
            4: r = 15 - (a & b);
`ifdef ALU_EXT_OPS_EN
            5: r = a ^ b;
            6: r = a | b;
            7: begin r = (a * 2) % 16; c = a / 8; end
`endif
            default: r = 0;
        endcase
        return 5'(c * 16 + r);
    endfunction

    task automatic cyc(input logic r, input logic fe, input logic la, input logic [7:0] pb,
                       input logic [2:0] f, input logic [3:0] db);
        logic [4:0] e;
        @(negedge clk);
        R = r; fetch_en = fe; loadA = la; programb = pb; fun = f; databus = db;
        #1;
        e = ref_alu(int'(f), int'(m_accu), int'(db));
        check("alu", 8'(alu), 8'(e[3:0]));
        check("carry", 8'(carry), 8'(e[4]));
        check("zero", 8'(zero), (e[3:0] == 4'h0) ? 8'h1 : 8'h0);
        @(posedge clk);
        #1;
        if (r) begin
            m_instr = 4'h0; m_oper = 4'h0; m_accu = 4'h0;
        end else begin
            if (fe) begin m_instr = pb[7:4]; m_oper = pb[3:0]; end
            if (la) m_accu = e[3:0];
        end
        check("instr", 8'(instr), 8'(m_instr));
        check("operando", 8'(operando), 8'(m_oper));
        check("accu", 8'(accu), 8'(m_accu));
    endtask

    initial begin
        R = 1'b1; fetch_en = 1'b1; loadA = 1'b1;
        @(posedge clk);
        #1;
        m_instr = 4'h0; m_oper = 4'h0; m_accu = 4'h0;
        check("rst_instr", 8'(instr), 8'h0);
        check("rst_operando", 8'(operando), 8'h0);
        check("rst_accu", 8'(accu), 8'h0);
        // reset overrides fetch and load
        cyc(1'b0, 1'b1, 1'b1, 8'hA5, 3'b010, 4'h9);
        cyc(1'b1, 1'b1, 1'b1, 8'h5A, 3'b011, 4'h1);
        // fetch then hold
        cyc(1'b0, 1'b1, 1'b0, 8'h3C, 3'b000, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 8'hFF, 3'b000, 4'h0);
        // add overflow F+1
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 3'b010, 4'hF);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 3'b011, 4'h1);
        // subtract equal and borrow
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 3'b010, 4'h5);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b001, 4'h5);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b001, 4'h6);
        // pass B then NAND
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 3'b010, 4'h7);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b100, 4'hF);
        // extended/undefined function codes
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 3'b010, 4'h9);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b111, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b101, 4'h6);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 3'b110, 4'h6);
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 8'($urandom),
                3'($urandom), 4'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
